wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data and PC width.
REQ-002 Parameter NREGS, default 32, architectural register count; RW = clog2(NREGS).
REQ-003 Parameter NWB, default 2, writeback lanes; lane NWB-1 is youngest in program order.
REQ-004 Parameter NRD, default 3, combinational read ports.
REQ-005 Parameter R0_ZERO, default 1, register 0 hardwired to zero when 1.
REQ-006 Port clk  in  1  sole clock; all state on posedge.
REQ-007 Port rst  in  1  reset, asynchronous, active-low.
REQ-008 Port stall  in  1  hold stage contents; suppress commit.
REQ-009 Port MEM  in  wb_lane_t[NWB]  per-lane pc, res, rd, w_rd, bubble from the memory stage.
REQ-010 Port out  out  wb_lane_t[NWB]  registered lane state; out.w_rd already gated by bubble.
REQ-011 Port rd_addr  in  NRD x RW  read addresses.
REQ-012 Port rd_data  out  NRD x XLEN  bypassed read data.
REQ-013 Port retired  out  64  count of committed non-bubble lanes.
REQ-014 Port regs  out  NREGS x XLEN  architectural register file, debug view.

Function
REQ-015 Each posedge with stall low, the lane registers SHALL capture MEM; with stall high they SHALL hold.
REQ-016 out[i].w_rd SHALL equal lane w_rd AND NOT lane bubble.
REQ-017 Commit SHALL occur at a posedge with stall low: every lane with out[i].w_rd set writes res to regs[rd].
REQ-018 With stall high, no regfile write SHALL occur; each lane SHALL commit exactly once, at the first unstalled edge.
REQ-019 Same-rd conflict between lanes in one commit: highest lane index SHALL win.
REQ-020 With R0_ZERO=1, writes to rd=0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-021 rd_data[p] SHALL equal the youngest lane in out with w_rd set and rd==rd_addr[p]; otherwise regs[rd_addr[p]] (zero-latency bypass of pending commit).
REQ-022 Bypass SHALL be valid while stalled (pending values visible before commit).
REQ-023 retired SHALL increment at each commit by the count of non-bubble lanes (0..NWB), wrapping modulo 2^64.
REQ-024 A lane with bubble set SHALL neither write nor count, regardless of w_rd.
REQ-025 Latency MEM to architectural state: 2 posedges when unstalled; MEM to rd_data: 1 posedge.
REQ-026 rd_addr >= NREGS (non-power-of-2 NREGS) SHALL read 0.

Reset
REQ-027 While rst low, all lanes SHALL report bubble=1, w_rd=0; pc, res, rd=0.
REQ-028 While rst low, regs SHALL be cleared to 0 and retired to 0.
REQ-029 Reset asserted mid-stall SHALL discard the pending lanes without commit.
REQ-030 First posedge after rst deasserts SHALL capture MEM normally; no commit of reset-state lanes.

Structure
REQ-031 wb_lane_t (pc, res, rd, w_rd, bubble) and default parameter constants SHALL live in pipeline_pkg.
REQ-032 Per-read-port bypass selection SHALL be a sub-module wb_fwd_mux, instantiated NRD times.
REQ-033 Regfile SHALL be flops (no inferred RAM) to permit async clear and NWB write ports.

Verification
REQ-034 Lane0 rd=5 res=0x11, lane1 rd=5 res=0x22, both valid -> regs[5]=0x22 after commit; retired +2.
REQ-035 Lane0 rd=0 res=0xDEAD, R0_ZERO=1 -> regs[0]=0, rd_data for addr 0 = 0, retired +1.
REQ-036 Lane1 rd=7 res=0x99 in out, stall high 3 cycles, rd_addr=7 -> rd_data=0x99 throughout, regs[7] updates only after stall drops, retired +1 once.
REQ-037 Lane0 bubble=1 w_rd=1 rd=3 res=0x5 -> regs[3] unchanged, out[0].w_rd=0, retired unchanged.
REQ-038 retired preloaded near 2^64-1 via 1 lane/cycle stream, two-lane commit across boundary -> wraps to 0 then 1 with no stall.
REQ-039 rst low during stall with lane0 rd=4 pending -> regs all 0, retired 0, no write to regs[4] after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and default parameters for the writeback stage.
// The lane struct is sized from the defaults below. Any module that carries
// wb_lane_t therefore has to be built with matching XLEN and NREGS values.
package pipeline_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_DEF   = 32;
    localparam int NWB_DEF     = 2;
    localparam int NRD_DEF     = 3;
    localparam int R0_ZERO_DEF = 1;
    localparam int LANE_RW     = $clog2(NREGS_DEF);

    // One writeback lane: result destined for rd, valid for commit only when
    // w_rd is set and the slot is not a bubble.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] res;
        logic [LANE_RW-1:0]  rd;
        logic                w_rd;
        logic                bubble;
    } wb_lane_t;

    localparam wb_lane_t LANE_RESET = '{
        pc:     '0,
        res:    '0,
        rd:     '0,
        w_rd:   1'b0,
        bubble: 1'b1
    };

endpackage

// File: rtl/wb_fwd_mux.sv
// Single read port: returns the youngest pending lane result for addr,
// otherwise the architectural value. Register 0 (when hardwired) and
// addresses beyond the register count always read as zero.
module wb_fwd_mux
    import pipeline_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NWB     = NWB_DEF,
    parameter int R0_ZERO = R0_ZERO_DEF,
    localparam int RW     = $clog2(NREGS)
) (
    input  wb_lane_t          lanes [NWB],
    input  logic [RW-1:0]     addr,
    input  logic [XLEN-1:0]   arch_data,
    output logic [XLEN-1:0]   data
);

    // pc and bubble are not needed here: w_rd in the lane register is
    // already gated by bubble.
    for (genvar l = 0; l < NWB; l++) begin : g_sink
        logic unused_lane_bits;
        assign unused_lane_bits = ^{lanes[l].pc, lanes[l].bubble};
    end

    // Scan lanes oldest to youngest so the youngest matching lane wins.
    always_comb begin
        data = arch_data;
        for (int l = 0; l < NWB; l++) begin
            if (lanes[l].w_rd && (lanes[l].rd == addr)) begin
                data = lanes[l].res;
            end
        end
        if ((R0_ZERO != 0) && (addr == '0)) begin
            data = '0;
        end
        if (32'(addr) >= NREGS) begin
            data = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: registers the memory-stage lanes, commits them into a
// flop-based architectural register file on the next unstalled edge, and
// forwards pending results to the read ports with zero latency.
module wb_regfile
    import pipeline_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NWB     = NWB_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int R0_ZERO = R0_ZERO_DEF,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  wb_lane_t          MEM     [NWB],
    output wb_lane_t          out     [NWB],
    input  logic [RW-1:0]     rd_addr [NRD],
    output logic [XLEN-1:0]   rd_data [NRD],
    output logic [63:0]       retired,
    output logic [XLEN-1:0]   regs    [NREGS]
);

    wb_lane_t        lanes_d [NWB];
    wb_lane_t        lanes_q [NWB];
    logic [XLEN-1:0] regs_q  [NREGS];
    logic [63:0]     retired_q;
    logic [63:0]     commit_cnt;
    logic [XLEN-1:0] arch_data [NRD];

    // Next lane contents: MEM with w_rd pre-gated by bubble so downstream
    // logic only has to look at w_rd.
    always_comb begin
        for (int l = 0; l < NWB; l++) begin
            lanes_d[l]      = MEM[l];
            lanes_d[l].w_rd = MEM[l].w_rd & ~MEM[l].bubble;
        end
    end

    // Lane register: capture on unstalled edges, hold while stalled; reset
    // turns every lane into a bubble so nothing pending survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < NWB; l++) begin
                lanes_q[l] <= LANE_RESET;
            end
        end else if (!stall) begin
            for (int l = 0; l < NWB; l++) begin
                lanes_q[l] <= lanes_d[l];
            end
        end
    end

    // Number of non-bubble lanes retiring at the next unstalled edge.
    always_comb begin
        commit_cnt = '0;
        for (int l = 0; l < NWB; l++) begin
            commit_cnt = commit_cnt + 64'(!lanes_q[l].bubble);
        end
    end

    // Architectural register file: lanes are applied in ascending order, so
    // on a same-rd conflict the highest (youngest) lane's write lands last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (!stall) begin
            for (int l = 0; l < NWB; l++) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (lanes_q[l].w_rd && (lanes_q[l].rd == RW'(r)) &&
                        !((R0_ZERO != 0) && (r == 0))) begin
                        regs_q[r] <= lanes_q[l].res;
                    end
                end
            end
        end
    end

    // Retired-instruction counter, free-running modulo 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (!stall) begin
            retired_q <= retired_q + commit_cnt;
        end
    end

    // Per-port architectural value, zero for addresses past the file.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign arch_data[p] = (32'(rd_addr[p]) < NREGS) ? regs_q[rd_addr[p]] : '0;

        wb_fwd_mux #(
            .XLEN    (XLEN),
            .NREGS   (NREGS),
            .NWB     (NWB),
            .R0_ZERO (R0_ZERO)
        ) u_fwd (
            .lanes     (lanes_q),
            .addr      (rd_addr[p]),
            .arch_data (arch_data[p]),
            .data      (rd_data[p])
        );
    end

    assign out     = lanes_q;
    assign regs    = regs_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed scenarios plus a randomized stream,
// each checked against a pending-commit reference model.
module tb_wb_regfile;
    import pipeline_pkg::*;

    localparam int NWB   = 2;
    localparam int NRD   = 3;
    localparam int NREGS = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall;
    wb_lane_t    mem_lanes [NWB];
    wb_lane_t    out_lanes [NWB];
    logic [4:0]  rd_addr   [NRD];
    logic [31:0] rd_data   [NRD];
    logic [63:0] retired;
    logic [31:0] regs      [NREGS];

    wb_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .MEM     (mem_lanes),
        .out     (out_lanes),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .retired (retired),
        .regs    (regs)
    );

    // reference model: architectural file plus the lanes awaiting commit
    logic [31:0] m_regs [NREGS];
    logic [63:0] m_ret;
    logic [31:0] p_pc  [NWB];
    logic [31:0] p_res [NWB];
    logic [4:0]  p_rd  [NWB];
    logic        p_w   [NWB];
    logic        p_bub [NWB];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_ret = '0;
        for (int l = 0; l < NWB; l++) begin
            p_pc[l] = '0; p_res[l] = '0; p_rd[l] = '0; p_w[l] = 1'b0; p_bub[l] = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_regs[a];
        for (int l = 0; l < NWB; l++)
            if (p_w[l] && !p_bub[l] && p_rd[l] == a) v = p_res[l];
        return v;
    endfunction

    // driver tasks
    task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] res,
                            input logic [4:0] rd, input logic w, input logic b);
        mem_lanes[l] = '{pc: pc, res: res, rd: rd, w_rd: w, bubble: b};
    endtask

    task automatic all_bubbles();
        for (int l = 0; l < NWB; l++) set_lane(l, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic rand_lanes(input int max_rd);
        for (int l = 0; l < NWB; l++)
            set_lane(l, $urandom, $urandom, 5'($urandom_range(0, max_rd)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    endtask

    // one clock edge; the model commits pending lanes, then takes MEM
    task automatic step(input logic s);
        stall = s;
        @(posedge clk);
        if (rst && !s) begin
            for (int l = 0; l < NWB; l++) begin
                if (!p_bub[l]) m_ret = m_ret + 64'd1;
                if (!p_bub[l] && p_w[l] && p_rd[l] != 5'd0) m_regs[p_rd[l]] = p_res[l];
            end
            for (int l = 0; l < NWB; l++) begin
                p_pc[l]  = mem_lanes[l].pc;
                p_res[l] = mem_lanes[l].res;
                p_rd[l]  = mem_lanes[l].rd;
                p_w[l]   = mem_lanes[l].w_rd;
                p_bub[l] = mem_lanes[l].bubble;
            end
        end
        #1;
    endtask

    // scoreboard comparison of every observable output against the model
    task automatic check_all(input string tag);
        chk({tag, ".retired"}, retired, m_ret);
        for (int r = 0; r < NREGS; r++)
            chk($sformatf("%s.regs%0d", tag, r), 64'(regs[r]), 64'(m_regs[r]));
        for (int l = 0; l < NWB; l++) begin
            chk($sformatf("%s.out%0d.bubble", tag, l), 64'(out_lanes[l].bubble), 64'(p_bub[l]));
            chk($sformatf("%s.out%0d.w_rd", tag, l), 64'(out_lanes[l].w_rd), 64'(p_w[l] & ~p_bub[l]));
            chk($sformatf("%s.out%0d.rd", tag, l), 64'(out_lanes[l].rd), 64'(p_rd[l]));
            chk($sformatf("%s.out%0d.res", tag, l), 64'(out_lanes[l].res), 64'(p_res[l]));
            chk($sformatf("%s.out%0d.pc", tag, l), 64'(out_lanes[l].pc), 64'(p_pc[l]));
        end
        for (int p = 0; p < NRD; p++)
            chk($sformatf("%s.rd_data%0d", tag, p), 64'(rd_data[p]), 64'(model_read(rd_addr[p])));
    endtask

    initial begin
        logic [63:0] ret_snap;

        // reset with garbage on MEM
        rst = 1'b0;
        stall = 1'b0;
        for (int p = 0; p < NRD; p++) rd_addr[p] = 5'(p + 3);
        rand_lanes(31);
        model_reset();
        repeat (3) step(1'b0);
        check_all("reset");
        chk("reset.retired0", retired, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // first edge after release: capture only, nothing from reset commits
        all_bubbles();
        step(1'b0);
        check_all("post_reset");

        // same-rd conflict: youngest lane wins, two retire
        ret_snap = m_ret;
        set_lane(0, 32'h100, 32'h11, 5'd5, 1'b1, 1'b0);
        set_lane(1, 32'h104, 32'h22, 5'd5, 1'b1, 1'b0);
        rd_addr[0] = 5'd5;
        step(1'b0);
        chk("conflict.bypass", 64'(rd_data[0]), 64'h22);
        all_bubbles();
        step(1'b0);
        chk("conflict.regs5", 64'(regs[5]), 64'h22);
        chk("conflict.retired", retired, ret_snap + 64'd2);
        check_all("conflict");

        // write to r0 discarded but counted
        ret_snap = m_ret;
        set_lane(0, 32'h108, 32'hDEAD, 5'd0, 1'b1, 1'b0);
        set_lane(1, 32'h10C, 32'h0, 5'd0, 1'b0, 1'b1);
        rd_addr[1] = 5'd0;
        step(1'b0);
        chk("r0.bypass", 64'(rd_data[1]), 64'd0);
        all_bubbles();
        step(1'b0);
        chk("r0.regs0", 64'(regs[0]), 64'd0);
        chk("r0.retired", retired, ret_snap + 64'd1);
        check_all("r0");

        // bubble with w_rd set neither writes nor counts
        ret_snap = m_ret;
        set_lane(0, 32'h110, 32'h5, 5'd3, 1'b1, 1'b1);
        set_lane(1, 32'h114, 32'h0, 5'd0, 1'b0, 1'b1);
        step(1'b0);
        chk("bubble.out0_w_rd", 64'(out_lanes[0].w_rd), 64'd0);
        all_bubbles();
        step(1'b0);
        chk("bubble.regs3", 64'(regs[3]), 64'd0);
        chk("bubble.retired", retired, ret_snap);

        // pending value visible through a 3-cycle stall, commits once
        ret_snap = m_ret;
        set_lane(0, 32'h118, 32'h0, 5'd0, 1'b0, 1'b1);
        set_lane(1, 32'h11C, 32'h99, 5'd7, 1'b1, 1'b0);
        rd_addr[2] = 5'd7;
        step(1'b0);
        for (int c = 0; c < 3; c++) begin
            rand_lanes(31);
            step(1'b1);
            chk($sformatf("stall%0d.bypass", c), 64'(rd_data[2]), 64'h99);
            chk($sformatf("stall%0d.regs7", c), 64'(regs[7]), 64'd0);
            chk($sformatf("stall%0d.retired", c), retired, ret_snap);
            check_all($sformatf("stall%0d", c));
        end
        all_bubbles();
        step(1'b0);
        chk("unstall.regs7", 64'(regs[7]), 64'h99);
        chk("unstall.retired", retired, ret_snap + 64'd1);
        step(1'b0);
        chk("unstall.retired_once", retired, ret_snap + 64'd1);

        // 1 lane/cycle stream followed by two-lane commits
        for (int c = 0; c < 20; c++) begin
            set_lane(0, $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
            set_lane(1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
            step(1'b0);
        end
        for (int c = 0; c < 20; c++) begin
            rand_lanes(31);
            mem_lanes[0].bubble = 1'b0;
            mem_lanes[1].bubble = 1'b0;
            step(1'b0);
        end
        check_all("stream");

        // randomized traffic with random stalls and read addresses
        for (int c = 0; c < 300; c++) begin
            rand_lanes(7);
            for (int p = 0; p < NRD; p++) rd_addr[p] = 5'($urandom_range(0, 8));
            step($urandom_range(0, 3) == 0);
            check_all($sformatf("rand%0d", c));
        end

        // reset in the middle of a stall discards the pending lane
        set_lane(0, 32'h200, 32'h44, 5'd4, 1'b1, 1'b0);
        set_lane(1, 32'h204, 32'h0, 5'd0, 1'b0, 1'b1);
        step(1'b0);
        step(1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("mid_stall_reset");
        step(1'b1);
        @(negedge clk);
        rst = 1'b1;
        all_bubbles();
        step(1'b0);
        step(1'b0);
        chk("after_reset.regs4", 64'(regs[4]), 64'd0);
        chk("after_reset.retired", retired, 64'd0);
        check_all("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
